// File: rtl/pci_bus_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : pci_bus_arbiter_pkg                                               |
// | Shared PCI arbitration types: state encoding, index widths, bus-idle test. |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
package pci_bus_arbiter_pkg;

    localparam int c_max_masters = 8;
    localparam int c_idx_w       = $clog2(c_max_masters);

    typedef logic [c_idx_w-1:0] idx_t;
    typedef logic [c_idx_w:0]   sum_t;
    typedef logic [7:0]         cnt_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEAD     = 2'd1,
        ST_GNT_WAIT = 2'd2,
        ST_BUSY     = 2'd3
    } arb_state_t;

    function automatic logic bus_idle(input logic frame_n, input logic irdy_n);
        return frame_n & irdy_n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pci_bus_arbiter_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : pci_bus_arbiter_rr_pick                                           |
// | Combinational round-robin picker: first active request at or after ptr.    |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module pci_bus_arbiter_rr_pick
    import pci_bus_arbiter_pkg::*;
#(
    parameter int N_MASTERS = 4
) (
    input  logic [N_MASTERS-1:0] req,
    input  logic [c_idx_w-1:0]   ptr,
    output logic [c_idx_w-1:0]   winner,
    output logic                 any_req
);

    typedef logic [N_MASTERS-1:0] vec_t;

    localparam sum_t c_n = sum_t'(N_MASTERS);

    vec_t w_rot;
    idx_t w_off;
    sum_t w_sum;

    // Rotating the doubled vector puts candidate ptr at bit 0, ptr+1 at bit 1, ...
    assign w_rot   = vec_t'({req, req} >> ptr);
    assign any_req = |req;

    always_comb begin
        w_off = '0;
        for (int i = N_MASTERS - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = idx_t'(i);
            end
        end
    end

    assign w_sum  = sum_t'(ptr) + sum_t'(w_off);
    assign winner = (w_sum >= c_n) ? idx_t'(w_sum - c_n) : idx_t'(w_sum);

endmodule
`default_nettype wire

// File: rtl/pci_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : pci_bus_arbiter                                                   |
// | Central PCI arbiter: round-robin grants, dead cycle, parking, idle timeout.|
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module pci_bus_arbiter
    import pci_bus_arbiter_pkg::*;
#(
    parameter int N_MASTERS   = 4,
    parameter int PARK_MASTER = 0,
    parameter int PARK_EN     = 1,
    parameter int MAX_IDLE    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_MASTERS-1:0] req_n,
    input  logic                 frame_n,
    input  logic                 irdy_n,
    output logic [N_MASTERS-1:0] gnt_n,
    output logic [c_idx_w-1:0]   owner,
    output logic                 owner_valid,
    output logic                 timeout
);

    typedef logic [N_MASTERS-1:0] vec_t;

    localparam vec_t c_all_off    = '1;
    localparam vec_t c_park_gnt_n = ~(vec_t'(1) << PARK_MASTER);
    localparam idx_t c_park_idx   = idx_t'(PARK_MASTER);
    localparam idx_t c_last_idx   = idx_t'(N_MASTERS - 1);
    localparam cnt_t c_max_idle   = cnt_t'(MAX_IDLE);
    localparam cnt_t c_cnt_sat    = '1;

    arb_state_t r_state, w_state;
    vec_t       r_gnt_n, w_gnt_n;
    idx_t       r_owner, w_owner;
    idx_t       r_winner, w_winner;
    idx_t       r_rr_ptr, w_rr_ptr;
    cnt_t       r_idle_cnt, w_idle_cnt;
    logic       r_owner_valid, w_owner_valid;
    logic       r_timeout, w_timeout;

    idx_t       w_pick;
    logic       w_any_req;
    logic       w_bus_idle;
    logic       w_parked;
    logic       w_owner_req;
    idx_t       w_owner_next;
    cnt_t       w_cnt;

    function automatic vec_t grant_vec(input idx_t idx);
        vec_t v;
        v = '1;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (idx_t'(i) == idx) begin
                v[i] = 1'b0;
            end
        end
        return v;
    endfunction

    pci_bus_arbiter_rr_pick #(
        .N_MASTERS (N_MASTERS)
    ) u_rr_pick (
        .req     (~req_n),
        .ptr     (r_rr_ptr),
        .winner  (w_pick),
        .any_req (w_any_req)
    );

    assign w_bus_idle   = bus_idle(frame_n, irdy_n);
    assign w_parked     = (r_state == ST_IDLE) && (r_gnt_n == c_park_gnt_n);
    assign w_owner_next = (r_owner == c_last_idx) ? '0 : r_owner + 1'b1;

    always_comb begin
        w_owner_req = 1'b0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (idx_t'(i) == r_owner) begin
                w_owner_req = !req_n[i];
            end
        end
    end

    always_comb begin
        w_state       = r_state;
        w_gnt_n       = r_gnt_n;
        w_owner       = r_owner;
        w_winner      = r_winner;
        w_owner_valid = r_owner_valid;
        w_rr_ptr      = r_rr_ptr;
        w_idle_cnt    = '0;
        w_timeout     = 1'b0;
        w_cnt         = (r_idle_cnt == c_cnt_sat) ? r_idle_cnt : r_idle_cnt + 1'b1;

        case (r_state)
            ST_IDLE: begin
                // A parked master may start a cycle without ever requesting.
                if (w_parked && !frame_n) begin
                    w_state       = ST_BUSY;
                    w_owner       = c_park_idx;
                    w_owner_valid = 1'b1;
                end else if (w_any_req) begin
                    w_winner = w_pick;
                    if (w_parked && (w_pick == c_park_idx)) begin
                        w_state       = ST_GNT_WAIT;
                        w_owner       = c_park_idx;
                        w_owner_valid = 1'b1;
                    end else begin
                        w_state       = ST_DEAD;
                        w_gnt_n       = c_all_off;
                        w_owner_valid = 1'b0;
                    end
                end else if (PARK_EN != 0) begin
                    w_gnt_n       = c_park_gnt_n;
                    w_owner       = c_park_idx;
                    w_owner_valid = 1'b1;
                end else begin
                    w_gnt_n       = c_all_off;
                    w_owner_valid = 1'b0;
                end
            end
            ST_DEAD: begin
                w_state       = ST_GNT_WAIT;
                w_gnt_n       = grant_vec(r_winner);
                w_owner       = r_winner;
                w_owner_valid = 1'b1;
            end
            ST_GNT_WAIT: begin
                if (!frame_n) begin
                    w_state = ST_BUSY;
                end else if (!w_owner_req) begin
                    w_state       = ST_IDLE;
                    w_gnt_n       = c_all_off;
                    w_owner_valid = 1'b0;
                end else begin
                    if (!w_bus_idle) begin
                        w_cnt = r_idle_cnt;
                    end
                    if (w_cnt == c_max_idle) begin
                        w_state       = ST_IDLE;
                        w_gnt_n       = c_all_off;
                        w_owner_valid = 1'b0;
                        w_timeout     = 1'b1;
                        w_rr_ptr      = w_owner_next;
                    end else begin
                        w_idle_cnt = w_cnt;
                    end
                end
            end
            ST_BUSY: begin
                // Grant goes away on the final data phase; ownership ends at bus idle.
                if (frame_n && (r_gnt_n != c_all_off)) begin
                    w_gnt_n  = c_all_off;
                    w_rr_ptr = w_owner_next;
                end
                if (w_bus_idle) begin
                    w_state       = ST_IDLE;
                    w_owner_valid = 1'b0;
                end
            end
            default: begin
                w_state       = ST_IDLE;
                w_gnt_n       = c_all_off;
                w_owner_valid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_gnt_n       <= c_all_off;
            r_owner       <= '0;
            r_winner      <= '0;
            r_owner_valid <= 1'b0;
            r_rr_ptr      <= '0;
            r_idle_cnt    <= '0;
            r_timeout     <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_gnt_n       <= w_gnt_n;
            r_owner       <= w_owner;
            r_winner      <= w_winner;
            r_owner_valid <= w_owner_valid;
            r_rr_ptr      <= w_rr_ptr;
            r_idle_cnt    <= w_idle_cnt;
            r_timeout     <= w_timeout;
        end
    end

    assign gnt_n       = r_gnt_n;
    assign owner       = r_owner;
    assign owner_valid = r_owner_valid;
    assign timeout     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_pci_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_pci_bus_arbiter                                                |
// | Directed scenarios plus random traffic against a cycle reference model.    |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_pci_bus_arbiter;

    localparam int N        = 4;
    localparam int PARK     = 0;
    localparam int PARK_EN  = 1;
    localparam int MAX_IDLE = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req_n;
    logic         frame_n;
    logic         irdy_n;
    logic [N-1:0] gnt_n;
    logic [2:0]   owner;
    logic         owner_valid;
    logic         timeout;

    pci_bus_arbiter #(
        .N_MASTERS   (N),
        .PARK_MASTER (PARK),
        .PARK_EN     (PARK_EN),
        .MAX_IDLE    (MAX_IDLE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_n       (req_n),
        .frame_n     (frame_n),
        .irdy_n      (irdy_n),
        .gnt_n       (gnt_n),
        .owner       (owner),
        .owner_valid (owner_valid),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: phase 0 arbitrate/park, 1 turnaround, 2 waiting for FRAME#, 3 transfer.
    int m_phase, m_rr, m_idle, m_next;
    int exp_gnt, exp_owner, exp_valid, exp_to;

    task automatic model_reset();
        m_phase = 0; m_rr = 0; m_idle = 0; m_next = 0;
        exp_gnt = -1; exp_owner = 0; exp_valid = 0; exp_to = 0;
    endtask

    function automatic int rr_first(input logic [N-1:0] rq_n, input int start);
        for (int i = 0; i < N; i++) begin
            if (!rq_n[(start + i) % N]) return (start + i) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] gnt_vec(input int g);
        logic [N-1:0] v;
        v = '1;
        if (g >= 0) v[g] = 1'b0;
        return v;
    endfunction

    task automatic model_step();
        bit quiet;
        bit parked;
        int w;
        quiet  = frame_n && irdy_n;
        parked = (m_phase == 0) && (exp_gnt == PARK);
        exp_to = 0;
        case (m_phase)
            0: begin
                w = rr_first(req_n, m_rr);
                if (parked && !frame_n) begin
                    m_phase = 3; exp_owner = PARK; exp_valid = 1;
                end else if (w >= 0 && parked && w == PARK) begin
                    m_phase = 2; m_idle = 0; exp_owner = PARK; exp_valid = 1;
                end else if (w >= 0) begin
                    m_phase = 1; m_next = w; exp_gnt = -1; exp_valid = 0;
                end else if (PARK_EN != 0) begin
                    exp_gnt = PARK; exp_owner = PARK; exp_valid = 1;
                end else begin
                    exp_gnt = -1; exp_valid = 0;
                end
            end
            1: begin
                m_phase = 2; m_idle = 0;
                exp_gnt = m_next; exp_owner = m_next; exp_valid = 1;
            end
            2: begin
                if (!frame_n) begin
                    m_phase = 3;
                end else if (req_n[exp_owner]) begin
                    m_phase = 0; exp_gnt = -1; exp_valid = 0;
                end else begin
                    if (quiet) m_idle = m_idle + 1;
                    if (m_idle >= MAX_IDLE) begin
                        m_phase = 0; exp_gnt = -1; exp_valid = 0; exp_to = 1;
                        m_rr = (exp_owner + 1) % N;
                    end
                end
            end
            default: begin
                if (frame_n && exp_gnt >= 0) begin
                    exp_gnt = -1; m_rr = (exp_owner + 1) % N;
                end
                if (quiet) begin
                    m_phase = 0; exp_valid = 0;
                end
            end
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check("gnt_n", 32'(gnt_n), 32'(gnt_vec(exp_gnt)));
        check("owner_valid", 32'(owner_valid), exp_valid);
        if (exp_valid != 0) check("owner", 32'(owner), exp_owner);
        check("timeout", 32'(timeout), exp_to);
        check("one_grant", 32'($countones(~gnt_n) <= 1), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int txn_pos, txn_len, stall;
        rst_n = 1'b0; req_n = '1; frame_n = 1'b1; irdy_n = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_gnt", 32'(gnt_n), 32'hF);
        check("rst_valid", 32'(owner_valid), 0);
        check("rst_owner", 32'(owner), 0);
        check("rst_timeout", 32'(timeout), 0);
        #2 rst_n = 1'b1;

        step();
        check("t1_park", 32'(gnt_n), 32'hE);
        check("t1_valid", 32'(owner_valid), 1);

        req_n = 4'b1011;
        step();
        check("t2_dead", 32'(gnt_n), 32'hF);
        step();
        check("t2_gnt", 32'(gnt_n), 32'hB);
        check("t2_owner", 32'(owner), 2);
        step();
        frame_n = 1'b0;
        step();
        frame_n = 1'b1; irdy_n = 1'b0; req_n = 4'b1111;
        step();
        check("t2_release", 32'(gnt_n), 32'hF);
        check("t2_own_hold", 32'(owner_valid), 1);
        irdy_n = 1'b1;
        step();
        step();
        check("t2_repark", 32'(gnt_n), 32'hE);

        req_n = 4'b1101;
        step();
        check("t4_dead", 32'(gnt_n), 32'hF);
        step();
        check("t4_gnt", 32'(gnt_n), 32'hD);
        req_n = 4'b1001;
        repeat (15) step();
        check("t4_early", 32'(timeout), 0);
        step();
        check("t4_timeout", 32'(timeout), 1);
        check("t4_gnt_off", 32'(gnt_n), 32'hF);
        step();
        check("t4_pulse", 32'(timeout), 0);
        step();
        check("t4_next", 32'(gnt_n), 32'hB);
        check("t4_next_owner", 32'(owner), 2);

        req_n = 4'b1011;
        repeat (15) step();
        frame_n = 1'b0;
        step();
        check("t5_no_timeout", 32'(timeout), 0);
        check("t5_gnt_held", 32'(gnt_n), 32'hB);
        check("t5_valid", 32'(owner_valid), 1);

        step();
        #3 rst_n = 1'b0;
        #1;
        check("t6_gnt", 32'(gnt_n), 32'hF);
        check("t6_valid", 32'(owner_valid), 0);
        check("t6_owner", 32'(owner), 0);
        check("t6_timeout", 32'(timeout), 0);
        model_reset();
        frame_n = 1'b1; irdy_n = 1'b1; req_n = '1;
        @(posedge clk);
        #2;
        check("t6_held", 32'(gnt_n), 32'hF);
        rst_n = 1'b1;
        step();
        check("t6_park", 32'(gnt_n), 32'hE);

        req_n = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            for (int w = 0; w < 8 && exp_gnt < 0; w++) step();
            check("t3_granted", 32'(gnt_n != 4'hF), 1);
            check("t3_order", 32'(owner), k % N);
            frame_n = 1'b0;
            step();
            frame_n = 1'b1; irdy_n = 1'b0;
            step();
            irdy_n = 1'b1;
            step();
        end

        txn_pos = -1; txn_len = 0; stall = 0;
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 11) == 0) req_n[b] = ~req_n[b];
            end
            if (stall > 0) stall--;
            else if ($urandom_range(0, 79) == 0) stall = 25;
            if (txn_pos > 0) begin
                if (txn_pos < txn_len) begin
                    frame_n = 1'b0; irdy_n = 1'b0; txn_pos++;
                end else begin
                    frame_n = 1'b1; irdy_n = 1'b0; txn_pos = -1;
                end
            end else begin
                frame_n = 1'b1; irdy_n = 1'b1;
                if (exp_gnt >= 0 && stall == 0 && $urandom_range(0, 3) == 0) begin
                    txn_len = $urandom_range(1, 4);
                    frame_n = 1'b0;
                    txn_pos = 1;
                end else if ($urandom_range(0, 63) == 0) begin
                    frame_n = 1'b0;
                end
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
